cam_match: RTL and testbench
============================

Name: cam_match

Overview:
- Parametrised, registered content-addressable match block; the sequential successor to the 3-bit equality comparator.
- Holds DEPTH entries of WIDTH-bit tags, each with a valid bit.
- Compares one lookup tag against all valid entries per cycle and returns a registered hit result: hit flag, lowest matching index, multi-hit flag and match vector.
- Intended as the tag-match core for TLB/BTB-style structures in later psets.

Parameters:
- WIDTH, 3: tag width in bits, >= 1.
- DEPTH, 8: number of entries, >= 2; need not be a power of two.
- IDX_W, $clog2(DEPTH): index width; derived localparam, not overridable.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high; clears all state immediately.
- wr_en  in  1  write strobe.
- wr_idx  in  IDX_W  entry to write.
- wr_tag  in  WIDTH  tag to store; entry becomes valid.
- inv_en  in  1  invalidate strobe.
- inv_idx  in  IDX_W  entry to invalidate.
- flush  in  1  invalidate all entries.
- lk_valid  in  1  lookup request this cycle.
- lk_tag  in  WIDTH  lookup tag.
- rsp_valid  out  1  lookup result valid; registered lk_valid.
- rsp_hit  out  1  at least one valid entry matched.
- rsp_idx  out  IDX_W  lowest matching index; 0 when no hit.
- rsp_multi  out  1  two or more valid entries matched.
- rsp_vec  out  DEPTH  per-entry match vector (bit i = entry i valid and tag equal).
- valid_vec  out  DEPTH  current valid bits, straight from state registers.

Behaviour:
- Reset (async, rst=1):
  - All valid bits = 0.
  - rsp_valid, rsp_hit, rsp_multi = 0; rsp_idx = 0; rsp_vec = 0; valid_vec = 0.
  - Tag storage need not be reset.
  - Reset mid-lookup discards the pending response.
  - First edge after deassertion behaves as normal.
- Lookup latency is exactly 1 cycle:
  - lk_valid/lk_tag sampled at edge N; result visible after edge N.
  - Fully pipelined: one lookup per cycle, back-to-back, no stall or backpressure.
- When lk_valid=0 at an edge:
  - rsp_valid goes 0.
  - rsp_hit, rsp_multi and rsp_vec go 0; rsp_idx goes 0.
- Match rule: entry i matches iff valid[i]=1 and tag[i]==lk_tag on all WIDTH bits. Invalid entries never match, whatever their stored tag.
- Read-before-write: a lookup compares against state before the same edge's write/invalidate/flush. A write of tag T and a lookup of T in the same cycle give a miss, unless T was already present.
- Update priority in the same cycle: flush > invalidate > write.
  - flush=1: all valid bits cleared; any write that cycle is dropped.
  - inv_en and wr_en on the same index: entry ends invalid; tag storage may update.
  - inv_en and wr_en on different indices: both take effect.
- Out-of-range index (wr_idx or inv_idx >= DEPTH): the operation is ignored; no entry changes.
- Duplicate tags may be written. The lookup then reports rsp_multi=1 and rsp_idx = lowest matching index.
- Rewriting a valid entry overwrites its tag; the entry stays valid.
- The design has no state machine beyond the valid/tag arrays and the one-stage response register.

Test Plan (WIDTH=3, DEPTH=8):
1. Reset then lookups: after rst pulse, lookup each tag 0..7 -> rsp_valid=1, rsp_hit=0, rsp_vec=0 one cycle after each request. Also assert rst mid-run with lk_valid=1 -> all rsp_* = 0 immediately.
2. Exhaustive single match:
   - Write entry i with tag i for i=0..7, then all 64 (entry, tag) checks.
   - Lookup tag j -> rsp_hit=1, rsp_idx=j, rsp_vec=1<<j, rsp_multi=0.
   - Lookups back-to-back every cycle, checked with 1-cycle latency.
3. Duplicates: write tag 5 to entries 2 and 6, others hold distinct non-5 tags. Lookup 5 -> rsp_hit=1, rsp_idx=2, rsp_multi=1, rsp_vec=8'b0100_0100.
4. Same-cycle hazards:
   - Write entry 3 tag 4 with a lookup of 4 in the same cycle (4 absent beforehand) -> miss; lookup 4 next cycle -> hit, idx 3.
   - wr_en and inv_en both on idx 3 -> valid_vec[3]=0.
5. Invalidate and flush:
   - inv_idx=6 -> a later lookup of its tag misses; valid_vec[6]=0.
   - flush together with wr_en to idx 1 -> valid_vec=0 and a later lookup misses.
6. Parameter sweep: WIDTH=5, DEPTH=5 (non-power-of-two).
   - wr_idx=7 is ignored; valid_vec remains 0.
   - Entry 4 with tag 31 -> lookup 31 hits with rsp_idx=4.

Source files
------------

// File: rtl/cam_match.sv
// ---------------------------------------------------------------------------
// cam_match: registered content-addressable tag match.
//
// Holds DEPTH entries of WIDTH-bit tags, each with a valid bit. Every cycle
// with lk_valid=1 the lookup tag is compared against all valid entries. One
// cycle later the block returns a hit flag, the lowest matching index, a
// multi-hit flag and the full match vector. Used as the tag-match core of
// TLB/BTB-style structures.
//
// Ports
//   clk        clock; all state updates on the rising edge
//   rst        asynchronous active-high reset; clears valid bits and response
//   wr_en      write strobe: store wr_tag at wr_idx and mark the entry valid
//   wr_idx     entry to write (indices >= DEPTH are ignored)
//   wr_tag     tag to store
//   inv_en     invalidate strobe: clear the valid bit of inv_idx
//   inv_idx    entry to invalidate (indices >= DEPTH are ignored)
//   flush      clear every valid bit; overrides write and invalidate
//   lk_valid   lookup request this cycle
//   lk_tag     lookup tag
//   rsp_valid  registered lk_valid
//   rsp_hit    at least one valid entry matched
//   rsp_idx    lowest matching index, 0 on miss
//   rsp_multi  two or more valid entries matched
//   rsp_vec    per-entry match vector
//   valid_vec  current valid bits
// ---------------------------------------------------------------------------
module cam_match #(
    parameter  int WIDTH = 3,
    parameter  int DEPTH = 8,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [WIDTH-1:0] wr_tag,
    input  logic             inv_en,
    input  logic [IDX_W-1:0] inv_idx,
    input  logic             flush,
    input  logic             lk_valid,
    input  logic [WIDTH-1:0] lk_tag,
    output logic             rsp_valid,
    output logic             rsp_hit,
    output logic [IDX_W-1:0] rsp_idx,
    output logic             rsp_multi,
    output logic [DEPTH-1:0] rsp_vec,
    output logic [DEPTH-1:0] valid_vec
);

    logic [DEPTH-1:0] valid_p0;
    logic [WIDTH-1:0] tag_mem [DEPTH];
    logic [DEPTH-1:0] wr_sel;
    logic [DEPTH-1:0] inv_sel;
    logic [DEPTH-1:0] match_p0;

    logic             vld_p1;
    logic             hit_p1;
    logic [IDX_W-1:0] idx_p1;
    logic             multi_p1;
    logic [DEPTH-1:0] vec_p1;

    // Lowest set bit of the match vector; 0 when nothing is set.
    function automatic logic [IDX_W-1:0] lowest_idx(input logic [DEPTH-1:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (v[i]) r = IDX_W'(i);
        end
        return r;
    endfunction

    // Clearing the lowest set bit leaves something only if two or more were set.
    function automatic logic more_than_one(input logic [DEPTH-1:0] v);
        return (v & (v - DEPTH'(1))) != '0;
    endfunction

    // Index decode. An index >= DEPTH matches no entry, so out-of-range
    // writes and invalidates fall away without an explicit range check.
    always_comb begin
        wr_sel  = '0;
        inv_sel = '0;
        for (int i = 0; i < DEPTH; i++) begin
            wr_sel[i]  = wr_en  && (wr_idx  == IDX_W'(i));
            inv_sel[i] = inv_en && (inv_idx == IDX_W'(i));
        end
    end

    // Valid bits: flush beats invalidate, invalidate beats write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_p0 <= '0;
        end else if (flush) begin
            valid_p0 <= '0;
        end else begin
            valid_p0 <= (valid_p0 | wr_sel) & ~inv_sel;
        end
    end

    // Tag storage carries no reset; a tag is only observed through its valid bit.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_sel[i]) tag_mem[i] <= wr_tag;
        end
    end

    // ---- stage p0: compare against pre-update state (read-before-write) ----
    always_comb begin
        match_p0 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match_p0[i] = valid_p0[i] && (tag_mem[i] == lk_tag);
        end
    end

    // ---- stage p1: registered response, zeroed on idle cycles ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1   <= 1'b0;
            hit_p1   <= 1'b0;
            idx_p1   <= '0;
            multi_p1 <= 1'b0;
            vec_p1   <= '0;
        end else if (lk_valid) begin
            vld_p1   <= 1'b1;
            hit_p1   <= |match_p0;
            idx_p1   <= lowest_idx(match_p0);
            multi_p1 <= more_than_one(match_p0);
            vec_p1   <= match_p0;
        end else begin
            vld_p1   <= 1'b0;
            hit_p1   <= 1'b0;
            idx_p1   <= '0;
            multi_p1 <= 1'b0;
            vec_p1   <= '0;
        end
    end

    assign rsp_valid = vld_p1;
    assign rsp_hit   = hit_p1;
    assign rsp_idx   = idx_p1;
    assign rsp_multi = multi_p1;
    assign rsp_vec   = vec_p1;
    assign valid_vec = valid_p0;

endmodule

// File: tb/tb_cam_match.sv
// ---------------------------------------------------------------------------
// tb_cam_match: bench for cam_match. One instance at WIDTH=3/DEPTH=8 runs a
// hand-derived vector table, a mid-run reset sequence and randomized traffic
// against a behavioural model; a second instance at WIDTH=5/DEPTH=5 covers
// the non-power-of-two geometry.
// ---------------------------------------------------------------------------
module tb_cam_match;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ---- instance A: WIDTH=3, DEPTH=8 ----
    logic       a_wr_en, a_inv_en, a_flush, a_lk_valid;
    logic [2:0] a_wr_idx, a_wr_tag, a_inv_idx, a_lk_tag;
    logic       a_rsp_valid, a_rsp_hit, a_rsp_multi;
    logic [2:0] a_rsp_idx;
    logic [7:0] a_rsp_vec, a_valid_vec;

    cam_match #(.WIDTH(3), .DEPTH(8)) dut_a (
        .clk(clk), .rst(rst),
        .wr_en(a_wr_en), .wr_idx(a_wr_idx), .wr_tag(a_wr_tag),
        .inv_en(a_inv_en), .inv_idx(a_inv_idx), .flush(a_flush),
        .lk_valid(a_lk_valid), .lk_tag(a_lk_tag),
        .rsp_valid(a_rsp_valid), .rsp_hit(a_rsp_hit), .rsp_idx(a_rsp_idx),
        .rsp_multi(a_rsp_multi), .rsp_vec(a_rsp_vec), .valid_vec(a_valid_vec)
    );

    // ---- instance B: WIDTH=5, DEPTH=5 ----
    logic       b_wr_en, b_inv_en, b_flush, b_lk_valid;
    logic [2:0] b_wr_idx, b_inv_idx;
    logic [4:0] b_wr_tag, b_lk_tag;
    logic       b_rsp_valid, b_rsp_hit, b_rsp_multi;
    logic [2:0] b_rsp_idx;
    logic [4:0] b_rsp_vec, b_valid_vec;

    cam_match #(.WIDTH(5), .DEPTH(5)) dut_b (
        .clk(clk), .rst(rst),
        .wr_en(b_wr_en), .wr_idx(b_wr_idx), .wr_tag(b_wr_tag),
        .inv_en(b_inv_en), .inv_idx(b_inv_idx), .flush(b_flush),
        .lk_valid(b_lk_valid), .lk_tag(b_lk_tag),
        .rsp_valid(b_rsp_valid), .rsp_hit(b_rsp_hit), .rsp_idx(b_rsp_idx),
        .rsp_multi(b_rsp_multi), .rsp_vec(b_rsp_vec), .valid_vec(b_valid_vec)
    );

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic       we;
        logic [2:0] wi, wt;
        logic       ie;
        logic [2:0] ii;
        logic       fl, lv;
        logic [2:0] lt;
        logic       hit;
        logic [2:0] idx;
        logic       multi;
        logic [7:0] vec;
        logic [7:0] vv;
    } row_t;

    row_t tbl[$];

    // Behavioural model of instance A: a plain list of entries.
    bit mdl_valid[8];
    int mdl_tag[8];

    function automatic row_t mk(logic we, logic [2:0] wi, logic [2:0] wt,
                                logic ie, logic [2:0] ii, logic fl,
                                logic lv, logic [2:0] lt, logic hit,
                                logic [2:0] idx, logic multi,
                                logic [7:0] vec, logic [7:0] vv);
        row_t r;
        r.we = we; r.wi = wi; r.wt = wt; r.ie = ie; r.ii = ii; r.fl = fl;
        r.lv = lv; r.lt = lt; r.hit = hit; r.idx = idx; r.multi = multi;
        r.vec = vec; r.vv = vv;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_a(input string nm, input logic v, input logic hit,
                           input logic [2:0] idx, input logic multi,
                           input logic [7:0] vec, input logic [7:0] vv);
        chk({nm, ".rsp_valid"}, 32'(a_rsp_valid), 32'(v));
        chk({nm, ".rsp_hit"},   32'(a_rsp_hit),   32'(hit));
        chk({nm, ".rsp_idx"},   32'(a_rsp_idx),   32'(idx));
        chk({nm, ".rsp_multi"}, 32'(a_rsp_multi), 32'(multi));
        chk({nm, ".rsp_vec"},   32'(a_rsp_vec),   32'(vec));
        chk({nm, ".valid_vec"}, 32'(a_valid_vec), 32'(vv));
    endtask

    task automatic check_b(input string nm, input logic v, input logic hit,
                           input logic [2:0] idx, input logic multi,
                           input logic [4:0] vec, input logic [4:0] vv);
        chk({nm, ".rsp_valid"}, 32'(b_rsp_valid), 32'(v));
        chk({nm, ".rsp_hit"},   32'(b_rsp_hit),   32'(hit));
        chk({nm, ".rsp_idx"},   32'(b_rsp_idx),   32'(idx));
        chk({nm, ".rsp_multi"}, 32'(b_rsp_multi), 32'(multi));
        chk({nm, ".rsp_vec"},   32'(b_rsp_vec),   32'(vec));
        chk({nm, ".valid_vec"}, 32'(b_valid_vec), 32'(vv));
    endtask

    // Advance one edge; outputs are then sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_a();
        a_wr_en = 0; a_wr_idx = 0; a_wr_tag = 0; a_inv_en = 0; a_inv_idx = 0;
        a_flush = 0; a_lk_valid = 0; a_lk_tag = 0;
    endtask

    task automatic idle_b();
        b_wr_en = 0; b_wr_idx = 0; b_wr_tag = 0; b_inv_en = 0; b_inv_idx = 0;
        b_flush = 0; b_lk_valid = 0; b_lk_tag = 0;
    endtask

    // Expected response for the current A inputs, then the state update.
    task automatic model_a(output logic hit, output logic [2:0] idx,
                           output logic multi, output logic [7:0] vec,
                           output logic [7:0] vv);
        int q[$];
        if (a_lk_valid)
            for (int e = 0; e < 8; e++)
                if (mdl_valid[e] && mdl_tag[e] == int'(a_lk_tag)) q.push_back(e);
        hit   = q.size() > 0;
        idx   = hit ? 3'(q[0]) : 3'd0;
        multi = q.size() > 1;
        vec   = '0;
        foreach (q[k]) vec[q[k]] = 1'b1;
        if (a_flush) begin
            for (int e = 0; e < 8; e++) mdl_valid[e] = 0;
        end else begin
            if (a_wr_en) begin
                mdl_tag[a_wr_idx]   = int'(a_wr_tag);
                mdl_valid[a_wr_idx] = 1;
            end
            if (a_inv_en) mdl_valid[a_inv_idx] = 0;
        end
        vv = '0;
        for (int e = 0; e < 8; e++) vv[e] = mdl_valid[e];
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       e_hit, e_multi;
        logic [2:0] e_idx;
        logic [7:0] e_vec, e_vv;

        // ---- vector table ----
        for (int j = 0; j < 8; j++)
            tbl.push_back(mk(0,0,0, 0,0,0, 1,3'(j), 0,0,0, 8'h00, 8'h00));
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(1,3'(i),3'(i), 0,0,0, 1,3'(i), 0,0,0, 8'h00,
                             8'((16'd1 << (i + 1)) - 16'd1)));
        for (int j = 0; j < 8; j++)
            tbl.push_back(mk(0,0,0, 0,0,0, 1,3'(j), 1,3'(j),0, 8'(16'd1 << j), 8'hFF));
        // duplicates: entries 2 and 6 both end up holding tag 5
        tbl.push_back(mk(1,2,5, 0,0,0, 0,0, 0,0,0, 8'h00, 8'hFF));
        tbl.push_back(mk(1,5,2, 0,0,0, 0,0, 0,0,0, 8'h00, 8'hFF));
        tbl.push_back(mk(1,6,5, 0,0,0, 1,5, 1,2,0, 8'h04, 8'hFF));
        tbl.push_back(mk(0,0,0, 0,0,0, 1,5, 1,2,1, 8'h44, 8'hFF));
        tbl.push_back(mk(0,0,0, 0,0,0, 1,2, 1,5,0, 8'h20, 8'hFF));
        // same-cycle hazards
        tbl.push_back(mk(0,0,0, 1,4,0, 1,4, 1,4,0, 8'h10, 8'hEF));
        tbl.push_back(mk(1,3,4, 0,0,0, 1,4, 0,0,0, 8'h00, 8'hEF));
        tbl.push_back(mk(0,0,0, 0,0,0, 1,4, 1,3,0, 8'h08, 8'hEF));
        tbl.push_back(mk(1,3,4, 1,3,0, 1,4, 1,3,0, 8'h08, 8'hE7));
        tbl.push_back(mk(0,0,0, 0,0,0, 1,4, 0,0,0, 8'h00, 8'hE7));
        // invalidate
        tbl.push_back(mk(0,0,0, 1,6,0, 1,5, 1,2,1, 8'h44, 8'hA7));
        tbl.push_back(mk(0,0,0, 0,0,0, 1,5, 1,2,0, 8'h04, 8'hA7));
        tbl.push_back(mk(0,0,0, 1,2,0, 1,5, 1,2,0, 8'h04, 8'hA3));
        tbl.push_back(mk(0,0,0, 0,0,0, 1,5, 0,0,0, 8'h00, 8'hA3));
        // flush with a simultaneous write
        tbl.push_back(mk(1,1,6, 0,0,1, 1,0, 1,0,0, 8'h01, 8'h00));
        tbl.push_back(mk(0,0,0, 0,0,0, 1,6, 0,0,0, 8'h00, 8'h00));
        tbl.push_back(mk(0,0,0, 0,0,0, 1,0, 0,0,0, 8'h00, 8'h00));

        // ---- reset state ----
        idle_a();
        idle_b();
        rst = 1'b1;
        #2;
        check_a("reset_a", 0, 0, 0, 0, 8'h00, 8'h00);
        check_b("reset_b", 0, 0, 0, 0, 5'h00, 5'h00);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // ---- table, back-to-back ----
        foreach (tbl[r]) begin
            a_wr_en = tbl[r].we; a_wr_idx = tbl[r].wi; a_wr_tag = tbl[r].wt;
            a_inv_en = tbl[r].ie; a_inv_idx = tbl[r].ii; a_flush = tbl[r].fl;
            a_lk_valid = tbl[r].lv; a_lk_tag = tbl[r].lt;
            step();
            check_a($sformatf("row%0d", r), tbl[r].lv, tbl[r].hit, tbl[r].idx,
                    tbl[r].multi, tbl[r].vec, tbl[r].vv);
        end

        // ---- reset during an outstanding lookup ----
        idle_a();
        a_wr_en = 1; a_wr_idx = 0; a_wr_tag = 1;
        step();
        idle_a();
        a_lk_valid = 1; a_lk_tag = 1;
        step();
        check_a("pre_rst", 1, 1, 0, 0, 8'h01, 8'h01);
        #2;
        rst = 1'b1;
        #1;
        check_a("mid_rst", 0, 0, 0, 0, 8'h00, 8'h00);
        step();
        check_a("held_rst", 0, 0, 0, 0, 8'h00, 8'h00);
        rst = 1'b0;
        step();
        check_a("post_rst", 1, 0, 0, 0, 8'h00, 8'h00);

        // ---- randomized traffic against the model ----
        for (int e = 0; e < 8; e++) begin
            mdl_valid[e] = 0;
            mdl_tag[e]   = 0;
        end
        for (int n = 0; n < 400; n++) begin
            a_wr_en    = ($urandom_range(0, 1) == 1);
            a_wr_idx   = 3'($urandom_range(0, 7));
            a_wr_tag   = 3'($urandom_range(0, 7));
            a_inv_en   = ($urandom_range(0, 3) == 0);
            a_inv_idx  = 3'($urandom_range(0, 7));
            a_flush    = ($urandom_range(0, 29) == 0);
            a_lk_valid = ($urandom_range(0, 3) != 0);
            a_lk_tag   = 3'($urandom_range(0, 7));
            model_a(e_hit, e_idx, e_multi, e_vec, e_vv);
            step();
            check_a($sformatf("rnd%0d", n), a_lk_valid, e_hit, e_idx, e_multi, e_vec, e_vv);
        end
        idle_a();

        // ---- instance B: non-power-of-two depth ----
        b_wr_en = 1; b_wr_idx = 7; b_wr_tag = 31;
        b_lk_valid = 1; b_lk_tag = 31;
        step();
        check_b("b_oob_wr", 1, 0, 0, 0, 5'h00, 5'h00);
        idle_b();
        b_lk_valid = 1; b_lk_tag = 31;
        step();
        check_b("b_oob_lk", 1, 0, 0, 0, 5'h00, 5'h00);
        idle_b();
        b_wr_en = 1; b_wr_idx = 4; b_wr_tag = 31;
        b_inv_en = 1; b_inv_idx = 5;
        step();
        check_b("b_wr4", 0, 0, 0, 0, 5'h00, 5'h10);
        idle_b();
        b_wr_en = 1; b_wr_idx = 0; b_wr_tag = 31;
        b_lk_valid = 1; b_lk_tag = 31;
        step();
        check_b("b_lk31", 1, 1, 4, 0, 5'h10, 5'h11);
        idle_b();
        b_lk_valid = 1; b_lk_tag = 31;
        step();
        check_b("b_dup31", 1, 1, 0, 1, 5'h11, 5'h11);
        idle_b();
        b_lk_valid = 1; b_lk_tag = 30;
        step();
        check_b("b_miss30", 1, 0, 0, 0, 5'h00, 5'h11);
        idle_b();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
